// File: rtl/z480_trap_seq.sv
// ---------------------------------------------------------------------------
// z480_trap_seq
//   Trap/interrupt entry-and-return sequencer for the Z480 privilege framework.
//   Selects a pending exception or enabled IRQ, asks the pipeline to drain,
//   saves PC/cause, switches privilege mode and redirects fetch to the handler
//   vector. Also performs the xRET restore (mode, PC, global enable).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   priv_mode[1:0]             current privilege mode (U=0, S=1, H=2, 3 as S)
//   tv_u/s/h_base[63:0]        trap vector bases per target mode
//   ie, ip[IRQ_N-1:0]          interrupt enable / pending snapshot
//   gie_we, gie_wdata          software write of the global interrupt enable
//   exc_valid, exc_cause[5:0]  synchronous exception (level until taken)
//   xret_valid                 xRET retired (1-cycle pulse)
//   drain_req                  stop-and-drain request to the pipeline
//   drain_done, drain_epc      pipeline drained; oldest unretired PC
//   redirect_valid/_pc         1-cycle fetch redirect
//   set_priv_valid/_mode       1-cycle privilege update strobe
//   epc, cause[6:0]            saved PC; cause[6]=1 means IRQ index in [5:0]
//   gie                        global interrupt enable
//   trap_busy                  sequencer is not idle
// ---------------------------------------------------------------------------
module z480_trap_seq #(
    parameter int IRQ_N       = 32,
    parameter int IRQ_VOFS    = 64,
    parameter int IRQ_VSTRIDE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       priv_mode,
    input  logic [63:0]      tv_u_base,
    input  logic [63:0]      tv_s_base,
    input  logic [63:0]      tv_h_base,
    input  logic [IRQ_N-1:0] ie,
    input  logic [IRQ_N-1:0] ip,
    input  logic             gie_we,
    input  logic             gie_wdata,
    input  logic             exc_valid,
    input  logic [5:0]       exc_cause,
    input  logic             xret_valid,
    output logic             drain_req,
    input  logic             drain_done,
    input  logic [63:0]      drain_epc,
    output logic             redirect_valid,
    output logic [63:0]      redirect_pc,
    output logic             set_priv_valid,
    output logic [1:0]       set_priv_mode,
    output logic [63:0]      epc,
    output logic [6:0]       cause,
    output logic             gie,
    output logic             trap_busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_H = 2'd2;

    state_e      r_state, w_state_nxt;
    logic        r_gie, r_saved_gie, r_ret;
    logic [1:0]  r_lpriv, r_saved_priv;
    logic [63:0] r_epc;
    logic [6:0]  r_cause;

    logic [IRQ_N-1:0] w_pend;
    logic             w_irq_hit;
    logic [5:0]       w_irq_idx;
    logic             w_take;
    logic [6:0]       w_take_cause;
    logic [1:0]       w_cur_priv;
    logic [1:0]       w_target;
    logic [63:0]      w_base;
    logic [63:0]      w_trap_pc;
    logic             w_unused;

    // User-mode traps are never targeted; the U base is accepted for
    // interface symmetry with the privilege-control block only.
    assign w_unused = ^tv_u_base ^ (priv_mode == PRIV_U);

    assign w_pend = ie & ip;

    // Lowest pending index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_irq_hit = 1'b0;
        w_irq_idx = '0;
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_irq_hit = 1'b1;
                w_irq_idx = 6'(i);
            end
        end
    end

    assign w_take       = exc_valid | (r_gie & w_irq_hit);
    assign w_take_cause = exc_valid ? {1'b0, exc_cause} : {1'b1, w_irq_idx};
    assign w_cur_priv   = (priv_mode == 2'd3) ? PRIV_S : priv_mode;

    assign w_target  = (r_lpriv == PRIV_H) ? PRIV_H : PRIV_S;
    assign w_base    = (w_target == PRIV_H) ? tv_h_base : tv_s_base;
    assign w_trap_pc = r_cause[6]
                     ? w_base + 64'(IRQ_VOFS) + 64'(r_cause[5:0]) * 64'(IRQ_VSTRIDE)
                     : w_base;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and strobe outputs.
    always_comb begin
        w_state_nxt    = r_state;
        drain_req      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = r_epc;
        set_priv_valid = 1'b0;
        set_priv_mode  = r_saved_priv;
        case (r_state)
            ST_IDLE: begin
                if (w_take) w_state_nxt = ST_DRAIN;
                // xRET restore strobe, registered one cycle after acceptance.
                redirect_valid = r_ret;
                set_priv_valid = r_ret;
            end
            ST_DRAIN: begin
                drain_req = 1'b1;
                if (drain_done) w_state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                w_state_nxt    = ST_IDLE;
                redirect_valid = 1'b1;
                redirect_pc    = w_trap_pc;
                set_priv_valid = 1'b1;
                set_priv_mode  = w_target;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Saved context, cause/epc capture and the global interrupt enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gie        <= 1'b0;
            r_saved_gie  <= 1'b0;
            r_saved_priv <= PRIV_S;
            r_lpriv      <= PRIV_S;
            r_epc        <= '0;
            r_cause      <= '0;
            r_ret        <= 1'b0;
        end else begin
            r_ret <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        // A trap in the same cycle as xRET drops the xRET.
                        r_cause <= w_take_cause;
                        r_lpriv <= w_cur_priv;
                        if (gie_we) r_gie <= gie_wdata;
                    end else if (xret_valid) begin
                        r_ret <= 1'b1;
                        r_gie <= r_saved_gie;
                    end else if (gie_we) begin
                        r_gie <= gie_wdata;
                    end
                end
                ST_DRAIN: begin
                    // An exception pre-empts a latched IRQ; once the cause is
                    // an exception, further events are ignored. A latched IRQ
                    // is never cancelled by ip/ie dropping.
                    if (exc_valid && r_cause[6]) r_cause <= {1'b0, exc_cause};
                    if (drain_done)              r_epc   <= drain_epc;
                end
                ST_COMMIT: begin
                    r_saved_priv <= r_lpriv;
                    r_saved_gie  <= r_gie;
                    r_gie        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign epc       = r_epc;
    assign cause     = r_cause;
    assign gie       = r_gie;
    assign trap_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_z480_trap_seq.sv
// ---------------------------------------------------------------------------
// tb_z480_trap_seq
//   Directed bench for z480_trap_seq (IRQ_N=64). Stimulus pushes the expected
//   redirect/privilege strobe into a scoreboard queue; a monitor on the
//   falling edge pops and compares whenever the DUT strobes.
// ---------------------------------------------------------------------------
module tb_z480_trap_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  priv_mode;
    logic [63:0] tv_u_base, tv_s_base, tv_h_base;
    logic [63:0] ie, ip;
    logic        gie_we, gie_wdata;
    logic        exc_valid;
    logic [5:0]  exc_cause;
    logic        xret_valid;
    logic        drain_req;
    logic        drain_done;
    logic [63:0] drain_epc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        set_priv_valid;
    logic [1:0]  set_priv_mode;
    logic [63:0] epc;
    logic [6:0]  cause;
    logic        gie;
    logic        trap_busy;

    z480_trap_seq #(.IRQ_N(64), .IRQ_VOFS(64), .IRQ_VSTRIDE(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .priv_mode      (priv_mode),
        .tv_u_base      (tv_u_base),
        .tv_s_base      (tv_s_base),
        .tv_h_base      (tv_h_base),
        .ie             (ie),
        .ip             (ip),
        .gie_we         (gie_we),
        .gie_wdata      (gie_wdata),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .xret_valid     (xret_valid),
        .drain_req      (drain_req),
        .drain_done     (drain_done),
        .drain_epc      (drain_epc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .set_priv_valid (set_priv_valid),
        .set_priv_mode  (set_priv_mode),
        .epc            (epc),
        .cause          (cause),
        .gie            (gie),
        .trap_busy      (trap_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [1:0]  mode;
        bit          is_trap;
        logic [6:0]  cause;
        logic [63:0] epc;
        logic        gie;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_trap(input logic [63:0] pc, input logic [1:0] mode,
                               input logic [6:0] c, input logic [63:0] e);
        exp_t x;
        x.pc = pc; x.mode = mode; x.is_trap = 1'b1; x.cause = c; x.epc = e; x.gie = 1'b0;
        sb_q.push_back(x);
    endtask

    task automatic expect_ret(input logic [63:0] pc, input logic [1:0] mode, input logic g);
        exp_t x;
        x.pc = pc; x.mode = mode; x.is_trap = 1'b0; x.cause = '0; x.epc = '0; x.gie = g;
        sb_q.push_back(x);
    endtask

    // Software write of gie with no interrupt pending, so it cannot trigger.
    task automatic set_gie(input logic v);
        ip        = '0;
        gie_we    = 1'b1;
        gie_wdata = v;
        tick(1);
        gie_we    = 1'b0;
    endtask

    // Called one cycle after the take: DUT is in DRAIN. Completes the drain
    // three cycles after the request first appears, then returns to IDLE.
    task automatic run_drain(input logic [63:0] pc);
        check("drain_req_asserted", {63'd0, drain_req}, 64'd1);
        tick(2);
        drain_done = 1'b1;
        drain_epc  = pc;
        tick(1);
        // COMMIT cycle: the exception is considered taken now.
        drain_done = 1'b0;
        exc_valid  = 1'b0;
        tick(1);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && (redirect_valid || set_priv_valid)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", {62'd0, redirect_valid, set_priv_valid}, 64'd0);
            end else begin
                exp_t x;
                x = sb_q.pop_front();
                check("redirect_valid", {63'd0, redirect_valid}, 64'd1);
                check("set_priv_valid", {63'd0, set_priv_valid}, 64'd1);
                check("redirect_pc", redirect_pc, x.pc);
                check("set_priv_mode", {62'd0, set_priv_mode}, {62'd0, x.mode});
                if (x.is_trap) begin
                    check("cause", {57'd0, cause}, {57'd0, x.cause});
                    check("epc", epc, x.epc);
                end else begin
                    check("ret_gie", {63'd0, gie}, {63'd0, x.gie});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        rst_n      = 1'b0;
        priv_mode  = 2'd0;
        tv_u_base  = 64'h0;
        tv_s_base  = 64'h1000;
        tv_h_base  = 64'h8000;
        ie         = '0;
        ip         = '0;
        gie_we     = 1'b0;
        gie_wdata  = 1'b0;
        exc_valid  = 1'b0;
        exc_cause  = '0;
        xret_valid = 1'b0;
        drain_done = 1'b0;
        drain_epc  = '0;
        tick(3);

        // Reset state.
        check("rst_drain_req", {63'd0, drain_req}, 64'd0);
        check("rst_gie", {63'd0, gie}, 64'd0);
        check("rst_epc", epc, 64'd0);
        check("rst_cause", {57'd0, cause}, 64'd0);
        check("rst_busy", {63'd0, trap_busy}, 64'd0);
        check("rst_redirect", {63'd0, redirect_valid}, 64'd0);
        rst_n = 1'b1;
        tick(1);

        // 1. IRQ 5 from U into S: 0x1000 + 64 + 5*8 = 0x1068.
        set_gie(1'b1);
        check("gie_write", {63'd0, gie}, 64'd1);
        priv_mode = 2'd0;
        ie = 64'h1 << 5;
        ip = 64'h1 << 5;
        expect_trap(64'h1068, 2'd1, 7'h45, 64'h2000);
        tick(1);
        check("busy_in_drain", {63'd0, trap_busy}, 64'd1);
        xret_valid = 1'b1;             // dropped outside IDLE
        tick(1);
        xret_valid = 1'b0;
        check("drain_req_held", {63'd0, drain_req}, 64'd1);
        tick(1);
        drain_done = 1'b1;
        drain_epc  = 64'h2000;
        tick(1);
        drain_done = 1'b0;
        tick(1);
        check("t1_gie_cleared", {63'd0, gie}, 64'd0);
        check("t1_cause", {57'd0, cause}, 64'h45);
        check("t1_epc", epc, 64'h2000);
        check("t1_idle", {63'd0, trap_busy}, 64'd0);
        ie = '0;
        ip = '0;

        // 2. Lowest enabled pending: ip=0x0C & ie=0x08 -> index 3.
        set_gie(1'b1);
        priv_mode = 2'd1;
        ie = 64'h08;
        ip = 64'h0C;
        expect_trap(64'h1058, 2'd1, 7'h43, 64'h5000);
        tick(1);
        run_drain(64'h5000);
        // Same pattern with gie=0 (cleared by the trap): never taken.
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (drain_req || trap_busy) seen = 1'b1;
        end
        check("t2_no_take_gie0", {63'd0, seen}, 64'd0);
        ie = '0;
        ip = '0;

        // 3. IRQ 1 latched, exception cause 2 during DRAIN replaces it.
        set_gie(1'b1);
        priv_mode = 2'd0;
        ie = 64'h2;
        ip = 64'h2;
        expect_trap(64'h1000, 2'd1, 7'h02, 64'h3000);
        tick(1);
        ip        = '0;                // dropping ip must not cancel
        exc_valid = 1'b1;
        exc_cause = 6'd2;
        tick(1);
        check("t3_cause_replaced", {57'd0, cause}, 64'h02);
        run_drain(64'h3000);
        // xRET back to U with gie restored.
        expect_ret(64'h3000, 2'd0, 1'b1);
        xret_valid = 1'b1;
        tick(1);
        xret_valid = 1'b0;
        tick(1);
        check("t3_gie_restored", {63'd0, gie}, 64'd1);
        ie = '0;

        // 4. Exception from H stays in H; IRQ 63 vector wraps modulo 2^64.
        priv_mode = 2'd2;
        tv_h_base = 64'hFFFF_FFFF_FFFF_FFF0;
        exc_valid = 1'b1;
        exc_cause = 6'd5;
        expect_trap(64'hFFFF_FFFF_FFFF_FFF0, 2'd2, 7'h05, 64'h6000);
        tick(1);
        run_drain(64'h6000);
        set_gie(1'b1);
        ie = 64'h1 << 63;
        ip = 64'h1 << 63;
        expect_trap(64'h0000_0000_0000_0228, 2'd2, 7'h7F, 64'h7000);
        tick(1);
        run_drain(64'h7000);
        ie = '0;
        ip = '0;

        // 5. xRET together with an exception: trap only; reserved priv 3 as S.
        priv_mode  = 2'd3;
        exc_valid  = 1'b1;
        exc_cause  = 6'd7;
        xret_valid = 1'b1;
        expect_trap(64'h1000, 2'd1, 7'h07, 64'h4000);
        tick(1);
        xret_valid = 1'b0;
        run_drain(64'h4000);
        tick(3);

        // 6. Asynchronous reset in DRAIN: immediate clear, no strobes later.
        set_gie(1'b1);
        ie = 64'h1;
        ip = 64'h1;
        tick(1);
        check("t6_in_drain", {63'd0, drain_req}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_drain_req", {63'd0, drain_req}, 64'd0);
        check("t6_rst_gie", {63'd0, gie}, 64'd0);
        check("t6_rst_busy", {63'd0, trap_busy}, 64'd0);
        ie = '0;
        ip = '0;
        tick(2);
        rst_n = 1'b1;
        tick(6);

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
